// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and req/ack instruction fetch front end that
// decodes each word into opcode/operand and issues it to the control unit.
module fetch_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int OPC_W = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'b10111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              instr_valid,
  input  logic              jump_en,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  typedef enum logic [1:0] {FETCH, ISSUE, EXEC, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, operand_q, operand_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic req_q, req_d;
  // opcode/operand registers form the instruction register, loaded on the ack edge
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    opcode_d = opcode_q;
    operand_d = operand_q;
    req_d = req_q;
    case (state_q)
      FETCH: begin
        req_d = 1'b1;
        if (req_q && imem_ack) begin
          req_d = 1'b0;
          opcode_d = imem_rdata[DATA_W-1 -: OPC_W];
          operand_d = imem_rdata[ADDR_W-1:0];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = (opcode_q == HALT_OPC) ? HALT : EXEC;
      EXEC: begin
        if (!stall) begin
          pc_d = jump_en ? operand_q : pc_q + ADDR_W'(1);
          req_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      opcode_q <= '0;
      operand_q <= '0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      opcode_q <= opcode_d;
      operand_q <= operand_d;
      req_q <= req_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign opcode = opcode_q;
  assign operand = operand_q;
  assign instr_valid = (state_q == ISSUE) && (opcode_q != HALT_OPC);
  assign halted = (state_q == HALT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: transaction-level model of fetch/issue/exec per instruction
// with randomized memory waits, stalls and jumps.
module tb_fetch_sequencer;
  localparam logic [4:0] HALT = 5'b10111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, instr_valid, jump_en = 1'b0, stall = 1'b0, halted;
  logic [10:0] imem_addr, operand, pc;
  logic [15:0] imem_rdata = '0;
  logic [4:0] opcode;
  logic [15:0] mem [0:2047];
  logic [10:0] mpc;
  int vectors = 0;
  int miscompares = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .opcode(opcode), .operand(operand),
    .instr_valid(instr_valid), .jump_en(jump_en), .stall(stall), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_reset(input string tag);
    vectors++;
    if ({imem_req, instr_valid, opcode, operand, halted, pc} !== 30'd0) begin
      miscompares++;
      $display("FAIL %s: req=%b valid=%b opc=%0h opd=%0h halted=%b pc=%0h, want all zero",
               tag, imem_req, instr_valid, opcode, operand, halted, pc);
    end
  endtask

  task automatic do_instr(input int waits, input int stalls, input bit jmp);
    logic [15:0] w;
    w = mem[mpc];
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      vectors++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, mpc, 1'b0}) begin
        miscompares++;
        $display("FAIL fetch: req/addr/valid=%b/%0h/%b want 1/%0h/0", imem_req, imem_addr, instr_valid, mpc);
      end
      imem_ack = (i == waits);
      imem_rdata = (i == waits) ? w : 16'($urandom);
      stall = 1'($urandom);
      jump_en = 1'($urandom);
    end
    @(negedge clk);
    vectors++;
    if ({imem_req, instr_valid, opcode, operand, halted} !== {1'b0, w[15:11] != HALT, w[15:11], w[10:0], 1'b0}) begin
      miscompares++;
      $display("FAIL issue pc=%0h: req=%b valid=%b opc=%0h opd=%0h want 0/%b/%0h/%0h",
               mpc, imem_req, instr_valid, opcode, operand, w[15:11] != HALT, w[15:11], w[10:0]);
    end
    imem_ack = 1'($urandom);
    stall = 1'($urandom);
    jump_en = 1'($urandom);
    if (w[15:11] == HALT) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        vectors++;
        if ({imem_req, instr_valid, halted, pc} !== {1'b0, 1'b0, 1'b1, mpc}) begin
          miscompares++;
          $display("FAIL halt: req=%b valid=%b halted=%b pc=%0h want 0/0/1/%0h", imem_req, instr_valid, halted, pc, mpc);
        end
        imem_ack = 1'($urandom);
        jump_en = 1'($urandom);
      end
    end else begin
      for (int s = 0; s <= stalls; s++) begin
        @(negedge clk);
        vectors++;
        if ({imem_req, instr_valid, pc, opcode, operand} !== {1'b0, 1'b0, mpc, w[15:11], w[10:0]}) begin
          miscompares++;
          $display("FAIL exec: req=%b valid=%b pc=%0h opc=%0h opd=%0h want 0/0/%0h/%0h/%0h",
                   imem_req, instr_valid, pc, opcode, operand, mpc, w[15:11], w[10:0]);
        end
        stall = (s < stalls);
        jump_en = (s < stalls) ? 1'(s) : jmp;
        imem_ack = 1'($urandom);
      end
      mpc = jmp ? w[10:0] : 11'((int'(mpc) + 1) % 2048);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    #1 check_reset("release");
    mpc = '0;
  endtask

  task automatic test_sequential;
    mem[0] = 16'h0000; mem[1] = 16'h6800; mem[2] = 16'h0801; mem[3] = 16'h9000;
    repeat (4) do_instr(0, 0, 1'b0);
  endtask

  task automatic test_wait_states;
    do_instr(0, 0, 1'b0);
    do_instr(4, 0, 1'b0);
  endtask

  task automatic test_jump;
    mem[mpc] = 16'hA02A;
    do_instr(0, 0, 1'b1);
    mem[11'h02A] = 16'hA02A;
    do_instr(0, 0, 1'b0);
  endtask

  task automatic test_stall;
    mem[mpc] = {5'b00011, 11'h155};
    do_instr(0, 3, 1'b1);
    do_instr(1, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 150; n++)
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
  endtask

  task automatic test_wrap_halt;
    mem[mpc] = {5'b00001, 11'h7FF};
    do_instr(0, 0, 1'b1);
    do_instr(0, 1, 1'b0);
    mem[0] = 16'hB800;
    do_instr(0, 0, 1'b0);
  endtask

  task automatic test_async_reset;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_from_halt");
    @(negedge clk);
    rst_n = 1'b1;
    mpc = '0;
    mem[0] = 16'h0000;
    do_instr(0, 0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 11'd1}) begin
      miscompares++;
      $display("FAIL pre_reset_fetch: req=%b addr=%0h want 1/1", imem_req, imem_addr);
    end
    imem_ack = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_fetch");
    imem_ack = 1'b1;
    imem_rdata = mem[1];
    @(negedge clk);
    check_reset("reset_held_ack");
    rst_n = 1'b1;
    mpc = '0;
    do_instr(0, 0, 1'b0);
    do_instr(2, 1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:11] == HALT) mem[i][15] = 1'b0;
    end
    test_reset;
    test_sequential;
    test_wait_states;
    test_jump;
    test_stall;
    test_random;
    test_wrap_halt;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
